// File: rtl/ibex_pkg.sv
// ibex_pkg: shared writeback-stage types and widths.
package ibex_pkg;
    localparam int RF_ADDR_W = 5;
    typedef enum logic [1:0] {
        WB_EMPTY     = 2'd0,
        WB_RESULT    = 2'd1,
        WB_LOAD_WAIT = 2'd2
    } wb_state_e;
endpackage

// File: rtl/wb_retire_counter.sv
// wb_retire_counter: wrapping retired-instruction counter with inhibit.
module wb_retire_counter #(
    parameter int RETIRE_CNT_W = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    inc,
    input  logic                    inhibit,
    output logic [RETIRE_CNT_W-1:0] count
);
    logic [RETIRE_CNT_W-1:0] count_d, count_q;

    always_comb count_d = (inc & ~inhibit) ? count_q + 1'b1 : count_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) count_q <= '0;
        else count_q <= count_d;
    end

    assign count = count_q;
endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback stage; drives RF writes for EX results and LSU load responses.
module wb_stage
    import ibex_pkg::*;
#(
    parameter int RETIRE_CNT_W = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    ex_valid_i,
    output logic                    wb_ready_o,
    input  logic                    ex_is_load_i,
    input  logic                    rf_we_ex_i,
    input  logic [RF_ADDR_W-1:0]    rf_waddr_ex_i,
    input  logic [31:0]             rf_wdata_ex_i,
    input  logic                    lsu_resp_valid_i,
    input  logic [31:0]             lsu_rdata_i,
    input  logic                    lsu_err_i,
    output logic                    rf_we_wb_o,
    output logic [RF_ADDR_W-1:0]    rf_waddr_wb_o,
    output logic [31:0]             rf_wdata_wb_o,
    output logic                    load_pending_o,
    output logic [RF_ADDR_W-1:0]    load_pending_waddr_o,
    output logic                    load_err_o,
    output logic                    instr_ret_o,
    input  logic                    cnt_inhibit_i,
    output logic [RETIRE_CNT_W-1:0] retire_cnt_o
);
    wb_state_e              state_d, state_q;
    logic                   we_d, we_q;
    logic [RF_ADDR_W-1:0]   waddr_d, waddr_q;
    logic [31:0]            wdata_d, wdata_q;
    logic                   accept, resp, done, waiting;

    always_comb begin
        waiting = (state_q == WB_LOAD_WAIT);
        resp    = waiting & lsu_resp_valid_i;
        done    = (state_q == WB_RESULT) | resp;
        // Ready rises in the response cycle so the next instruction overlaps the load write.
        wb_ready_o = ~waiting | lsu_resp_valid_i;
        accept     = ex_valid_i & wb_ready_o;
        state_d = accept ? (ex_is_load_i ? WB_LOAD_WAIT : WB_RESULT)
                         : (done ? WB_EMPTY : state_q);
        we_d    = accept ? rf_we_ex_i    : we_q;
        waddr_d = accept ? rf_waddr_ex_i : waddr_q;
        wdata_d = accept ? rf_wdata_ex_i : wdata_q;
        rf_we_wb_o = (waddr_q != '0) & we_q &
                     ((state_q == WB_RESULT) | (resp & ~lsu_err_i));
        rf_waddr_wb_o        = waddr_q;
        rf_wdata_wb_o        = resp ? lsu_rdata_i : wdata_q;
        load_pending_o       = waiting;
        load_pending_waddr_o = waiting ? waddr_q : '0;
        load_err_o           = resp & lsu_err_i;
        instr_ret_o          = done;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= WB_EMPTY;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    wb_retire_counter #(.RETIRE_CNT_W(RETIRE_CNT_W)) u_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc     (instr_ret_o),
        .inhibit (cnt_inhibit_i),
        .count   (retire_cnt_o)
    );

    // A response with nothing outstanding must never surface as a load error.
    spurious_resp_ignored: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (lsu_resp_valid_i && !waiting) |-> !load_err_o);
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed tests for wb_stage built with a 4-bit retire counter.
module tb_wb_stage;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        ex_valid_i, ex_is_load_i, rf_we_ex_i;
    logic [4:0]  rf_waddr_ex_i;
    logic [31:0] rf_wdata_ex_i;
    logic        lsu_resp_valid_i, lsu_err_i;
    logic [31:0] lsu_rdata_i;
    logic        wb_ready_o, rf_we_wb_o, load_pending_o, load_err_o, instr_ret_o;
    logic [4:0]  rf_waddr_wb_o, load_pending_waddr_o;
    logic [31:0] rf_wdata_wb_o;
    logic        cnt_inhibit_i;
    logic [3:0]  retire_cnt_o;
    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    wb_stage #(.RETIRE_CNT_W(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ex_valid_i(ex_valid_i), .wb_ready_o(wb_ready_o),
        .ex_is_load_i(ex_is_load_i), .rf_we_ex_i(rf_we_ex_i),
        .rf_waddr_ex_i(rf_waddr_ex_i), .rf_wdata_ex_i(rf_wdata_ex_i),
        .lsu_resp_valid_i(lsu_resp_valid_i), .lsu_rdata_i(lsu_rdata_i),
        .lsu_err_i(lsu_err_i), .rf_we_wb_o(rf_we_wb_o),
        .rf_waddr_wb_o(rf_waddr_wb_o), .rf_wdata_wb_o(rf_wdata_wb_o),
        .load_pending_o(load_pending_o), .load_pending_waddr_o(load_pending_waddr_o),
        .load_err_o(load_err_o), .instr_ret_o(instr_ret_o),
        .cnt_inhibit_i(cnt_inhibit_i), .retire_cnt_o(retire_cnt_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic ex(input logic v, input logic ld, input logic we, input logic [4:0] a, input logic [31:0] d);
        ex_valid_i = v; ex_is_load_i = ld; rf_we_ex_i = we; rf_waddr_ex_i = a; rf_wdata_ex_i = d;
    endtask

    task automatic lsu(input logic v, input logic e, input logic [31:0] d);
        lsu_resp_valid_i = v; lsu_err_i = e; lsu_rdata_i = d;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; cnt_inhibit_i = 1'b0;
        ex(0, 0, 0, 0, 0); lsu(0, 0, 0);
        tick(); tick();
        rst_ni = 1'b1;
        @(negedge clk_i);
        checks++; if (wb_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", wb_ready_o); end
        checks++; if ({rf_we_wb_o, load_pending_o, load_err_o, instr_ret_o} !== 4'b0) begin errors++; $display("FAIL rst_flags got=%b exp=0000", {rf_we_wb_o, load_pending_o, load_err_o, instr_ret_o}); end
        checks++; if ({rf_waddr_wb_o, rf_wdata_wb_o, load_pending_waddr_o} !== 42'd0) begin errors++; $display("FAIL rst_data got=%h/%h/%h exp=0", rf_waddr_wb_o, rf_wdata_wb_o, load_pending_waddr_o); end
        checks++; if (retire_cnt_o !== 4'd0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", retire_cnt_o); end
    endtask

    task automatic test_alu();
        tick(); ex(1, 0, 1, 5, 32'hDEADBEEF);
        tick(); ex(0, 0, 0, 0, 0);
        @(negedge clk_i);
        checks++; if ({rf_we_wb_o, instr_ret_o} !== 2'b11) begin errors++; $display("FAIL alu_we_ret got=%b exp=11", {rf_we_wb_o, instr_ret_o}); end
        checks++; if (rf_waddr_wb_o !== 5'd5 || rf_wdata_wb_o !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_wr got=%0d/%h exp=5/deadbeef", rf_waddr_wb_o, rf_wdata_wb_o); end
        tick(); @(negedge clk_i);
        checks++; if (retire_cnt_o !== 4'd1 || rf_we_wb_o !== 1'b0) begin errors++; $display("FAIL alu_cnt got=%0d we=%b exp=1 we=0", retire_cnt_o, rf_we_wb_o); end
    endtask

    task automatic test_load();
        tick(); ex(1, 1, 1, 7, 0);
        tick(); ex(0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            checks++; if ({wb_ready_o, load_pending_o, rf_we_wb_o} !== 3'b010 || load_pending_waddr_o !== 5'd7) begin errors++; $display("FAIL load_wait%0d got=%b/%0d exp=010/7", i, {wb_ready_o, load_pending_o, rf_we_wb_o}, load_pending_waddr_o); end
            tick();
        end
        lsu(1, 0, 32'h80);
        @(negedge clk_i);
        checks++; if ({rf_we_wb_o, wb_ready_o, instr_ret_o, load_err_o} !== 4'b1110) begin errors++; $display("FAIL load_resp got=%b exp=1110", {rf_we_wb_o, wb_ready_o, instr_ret_o, load_err_o}); end
        checks++; if (rf_waddr_wb_o !== 5'd7 || rf_wdata_wb_o !== 32'h80) begin errors++; $display("FAIL load_wr got=%0d/%h exp=7/80", rf_waddr_wb_o, rf_wdata_wb_o); end
        tick(); lsu(0, 0, 0);
        @(negedge clk_i);
        checks++; if (load_pending_o !== 1'b0 || load_pending_waddr_o !== 5'd0 || retire_cnt_o !== 4'd2) begin errors++; $display("FAIL load_done got=%b/%0d/%0d exp=0/0/2", load_pending_o, load_pending_waddr_o, retire_cnt_o); end
    endtask

    task automatic test_back_to_back();
        tick(); ex(1, 1, 1, 7, 0);
        tick(); ex(1, 0, 1, 9, 32'h1234); lsu(1, 0, 32'h55);
        @(negedge clk_i);
        checks++; if ({rf_we_wb_o, wb_ready_o} !== 2'b11 || rf_waddr_wb_o !== 5'd7 || rf_wdata_wb_o !== 32'h55) begin errors++; $display("FAIL b2b_load got=%b/%0d/%h exp=11/7/55", {rf_we_wb_o, wb_ready_o}, rf_waddr_wb_o, rf_wdata_wb_o); end
        tick(); ex(0, 0, 0, 0, 0); lsu(0, 0, 0);
        @(negedge clk_i);
        checks++; if ({rf_we_wb_o, instr_ret_o} !== 2'b11 || rf_waddr_wb_o !== 5'd9 || rf_wdata_wb_o !== 32'h1234) begin errors++; $display("FAIL b2b_alu got=%b/%0d/%h exp=11/9/1234", {rf_we_wb_o, instr_ret_o}, rf_waddr_wb_o, rf_wdata_wb_o); end
        tick(); @(negedge clk_i);
        checks++; if (retire_cnt_o !== 4'd4 || rf_we_wb_o !== 1'b0) begin errors++; $display("FAIL b2b_cnt got=%0d we=%b exp=4 we=0", retire_cnt_o, rf_we_wb_o); end
    endtask

    task automatic test_err_x0();
        tick(); ex(1, 1, 1, 3, 0);
        tick(); ex(0, 0, 0, 0, 0); lsu(1, 1, 32'hFFFF);
        @(negedge clk_i);
        checks++; if ({rf_we_wb_o, load_err_o, instr_ret_o} !== 3'b011) begin errors++; $display("FAIL load_err got=%b exp=011", {rf_we_wb_o, load_err_o, instr_ret_o}); end
        tick(); lsu(0, 0, 0); ex(1, 0, 1, 0, 32'h99);
        tick(); ex(0, 0, 0, 0, 0);
        @(negedge clk_i);
        checks++; if ({rf_we_wb_o, instr_ret_o, load_err_o} !== 3'b010) begin errors++; $display("FAIL x0_write got=%b exp=010", {rf_we_wb_o, instr_ret_o, load_err_o}); end
        tick(); @(negedge clk_i);
        checks++; if (retire_cnt_o !== 4'd6) begin errors++; $display("FAIL err_x0_cnt got=%0d exp=6", retire_cnt_o); end
    endtask

    task automatic test_wrap_inhibit();
        tick(); ex(1, 0, 1, 1, 32'h1);
        repeat (9) tick();
        ex(0, 0, 0, 0, 0);
        tick(); @(negedge clk_i);
        checks++; if (retire_cnt_o !== 4'd15) begin errors++; $display("FAIL cnt_max got=%0d exp=15", retire_cnt_o); end
        tick(); ex(1, 0, 1, 1, 32'h2);
        tick(); ex(0, 0, 0, 0, 0);
        tick(); @(negedge clk_i);
        checks++; if (retire_cnt_o !== 4'd0) begin errors++; $display("FAIL cnt_wrap got=%0d exp=0", retire_cnt_o); end
        tick(); ex(1, 0, 1, 2, 32'h3); cnt_inhibit_i = 1'b1;
        tick(); tick(); ex(0, 0, 0, 0, 0);
        @(negedge clk_i);
        checks++; if (instr_ret_o !== 1'b1) begin errors++; $display("FAIL inh_ret got=%b exp=1", instr_ret_o); end
        tick(); cnt_inhibit_i = 1'b0;
        @(negedge clk_i);
        checks++; if (retire_cnt_o !== 4'd0) begin errors++; $display("FAIL cnt_inhibit got=%0d exp=0", retire_cnt_o); end
    endtask

    task automatic test_reset_mid_load();
        tick(); ex(1, 1, 1, 12, 0);
        tick(); ex(0, 0, 0, 0, 0);
        @(negedge clk_i);
        checks++; if (load_pending_o !== 1'b1 || load_pending_waddr_o !== 5'd12) begin errors++; $display("FAIL mid_pend got=%b/%0d exp=1/12", load_pending_o, load_pending_waddr_o); end
        tick(); rst_ni = 1'b0;
        tick(); rst_ni = 1'b1;
        @(negedge clk_i);
        checks++; if ({load_pending_o, wb_ready_o} !== 2'b01 || load_pending_waddr_o !== 5'd0) begin errors++; $display("FAIL mid_rst got=%b/%0d exp=01/0", {load_pending_o, wb_ready_o}, load_pending_waddr_o); end
        tick(); lsu(1, 0, 32'hAB);
        @(negedge clk_i);
        checks++; if ({rf_we_wb_o, instr_ret_o, load_err_o, wb_ready_o} !== 4'b0001) begin errors++; $display("FAIL stale_resp got=%b exp=0001", {rf_we_wb_o, instr_ret_o, load_err_o, wb_ready_o}); end
        tick(); lsu(0, 0, 0);
        @(negedge clk_i);
        checks++; if (retire_cnt_o !== 4'd0 || load_pending_o !== 1'b0) begin errors++; $display("FAIL stale_cnt got=%0d/%b exp=0/0", retire_cnt_o, load_pending_o); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_back_to_back();
        test_err_x0();
        test_wrap_inhibit();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Writeback stage directly downstream of the execute stage. It captures the EX result (address, data, write enable) through a valid/ready handshake. For ALU, multiply/divide and CSR results it drives the register-file write port one cycle later. For loads it holds the entry until the LSU response arrives, then writes the load data. It also provides load-hazard status to ID and a retired-instruction counter.

Parameters:
RETIRE_CNT_W, 64, width of retired-instruction counter.

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
ex_valid_i  in  1  EX has a completed instruction this cycle
wb_ready_o  out  1  WB can accept an EX instruction this cycle
ex_is_load_i  in  1  accepted instruction is a load; data comes from LSU
rf_we_ex_i  in  1  EX register-file write enable
rf_waddr_ex_i  in  5  EX destination register
rf_wdata_ex_i  in  32  EX result, already muxed with CSR read data
lsu_resp_valid_i  in  1  LSU load response valid, single-cycle pulse
lsu_rdata_i  in  32  LSU load data, already aligned and sign-extended
lsu_err_i  in  1  LSU bus error, qualified by lsu_resp_valid_i
rf_we_wb_o  out  1  register-file write enable
rf_waddr_wb_o  out  5  register-file write address
rf_wdata_wb_o  out  32  register-file write data
load_pending_o  out  1  load outstanding in WB
load_pending_waddr_o  out  5  destination of outstanding load (0 when none)
load_err_o  out  1  pulse: load completed with error
instr_ret_o  out  1  pulse: instruction retired
cnt_inhibit_i  in  1  freeze retire counter
retire_cnt_o  out  RETIRE_CNT_W  retired-instruction count

Behaviour:
- Reset: state WB_EMPTY; held we/waddr/wdata/is_load cleared. All outputs 0 except wb_ready_o=1. retire_cnt_o=0.
- Accept condition: accept = ex_valid_i & wb_ready_o.
- wb_ready_o = (state != WB_LOAD_WAIT) | lsu_resp_valid_i. This is a combinational path from lsu_resp_valid_i.
- States and transitions:
  - WB_EMPTY: no output activity. Accept non-load -> WB_RESULT. Accept load -> WB_LOAD_WAIT. Otherwise stay.
  - WB_RESULT: rf_we_wb_o = held_we & (held_waddr!=0). Write address and data come from the held registers. instr_ret_o=1. Leaves the state after exactly one cycle: accept non-load -> WB_RESULT, accept load -> WB_LOAD_WAIT, else -> WB_EMPTY.
  - WB_LOAD_WAIT: load_pending_o=1; load_pending_waddr_o = held_waddr. Outputs rf_we_wb_o=0 until lsu_resp_valid_i.
  - On lsu_resp_valid_i in WB_LOAD_WAIT:
    - rf_we_wb_o = held_we & ~lsu_err_i & (held_waddr!=0)
    - rf_wdata_wb_o = lsu_rdata_i (combinational pass-through)
    - load_err_o = lsu_err_i; instr_ret_o=1
    - next state per same-cycle accept as in WB_RESULT, else WB_EMPTY.
- Latency:
  - Non-load: RF write in cycle N+1 after acceptance in cycle N.
  - Load: RF write in the same cycle as the LSU response, earliest N+1.
- Back-to-back: a new instruction is accepted while the previous one writes back, giving full throughput for non-loads.
- lsu_resp_valid_i in WB_EMPTY or WB_RESULT is spurious. It is ignored, with no state change, and covered by an assertion.
- A write to x0 is never driven (rf_we_wb_o=0), but the instruction still retires.
- Loads with a bus error retire and do not write the register file.
- Retire counter:
  - Increments by 1 when instr_ret_o & ~cnt_inhibit_i.
  - Wraps from all-ones to 0.
- Reset asserted mid-load: entry dropped, state WB_EMPTY next cycle. A later stale response is treated as spurious.
- Outputs rf_waddr_wb_o/rf_wdata_wb_o are don't-care when rf_we_wb_o=0 but must not be X after reset.

Decomposition:
- Shared package ibex_pkg:
  - wb_state_e enum {WB_EMPTY, WB_RESULT, WB_LOAD_WAIT}
  - localparam RF_ADDR_W=5
- One sub-module, wb_retire_counter. Inputs: clk_i, rst_ni, inc, inhibit. Output: count. Parameterised by RETIRE_CNT_W.

Test Plan:
- Reset then ex_valid_i=1, is_load=0, we=1, waddr=5, wdata=0xDEADBEEF -> next cycle rf_we_wb_o=1, waddr=5, wdata=0xDEADBEEF, instr_ret_o=1, retire_cnt_o=1.
- Load to x7 accepted, lsu_resp_valid_i after 3 cycles with rdata=0x0000_0080 -> wb_ready_o=0 and load_pending_o=1 with waddr 7 for 2 cycles; write x7=0x80 in the response cycle.
- Response cycle coincides with ex_valid_i for ALU write x9=0x1234 -> x7 written that cycle, x9 written the next cycle, no lost instruction, retire_cnt_o +2.
- Load with lsu_err_i=1 -> rf_we_wb_o=0, load_err_o=1, instr_ret_o=1. Also an ALU write to x0 -> rf_we_wb_o=0, retire counted.
- Preload counter near the all-ones boundary (use RETIRE_CNT_W=4 build) with 2 retirements -> wraps 15 -> 0. Retirements while cnt_inhibit_i=1 leave the count unchanged.
- rst_ni low during WB_LOAD_WAIT, then a late lsu_resp_valid_i -> state WB_EMPTY, no RF write, wb_ready_o=1.
